color_scan_arbiter: RTL and testbench
=====================================

# color_scan_arbiter

Shares the single `color_detector` instance between two independent requesters, e.g. the UART command handler and the navigation FSM. It sequences each scan:
- arbitrate round-robin;
- wait for a camera frame boundary;
- freeze the frame-buffer writer;
- pulse the detector's start;
- collect the ASCII colour code;
- release the buffer and hand the result back with a one-cycle acknowledge.

It sits between the requesters, the camera capture block and `color_detector`.

## Interface
- `TIMEOUT`, default 16384: cycles allowed from `detect_color` pulse to `det_done` before aborting; must be ≥ 2.
- `clk`  in  1  system clock, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  2  scan request per requester; level, held high until its `ack` bit is seen.
- `ack`  out  2  one-cycle pulse to the granted requester; `result`/`result_err` are valid in that cycle and held until the next grant completes.
- `result`  out  8  colour code: `R` = 8'h52, `G` = 8'h47, `B` = 8'h42, `N` = 8'h4E, or `E` = 8'h45 on timeout.
- `result_err`  out  1  high when `result` came from a timeout.
- `busy`  out  1  high in every state except IDLE.
- `cam_frame_end`  in  1  one-cycle pulse from capture block at end of frame.
- `cam_freeze`  out  1  high blocks frame-buffer writes.
- `detect_color`  out  1  one-cycle start pulse to detector.
- `det_done`  in  1  detector done pulse.
- `det_color`  in  8  detector `color_decision`, valid with `det_done`.

## Operation
States and transitions:
- **IDLE**: when `ack` is nonzero this cycle, all requests are ignored. This prevents re-granting a requester that has not yet dropped `req`. Otherwise, on any `req` bit, pick the grant, store `gnt_id`, go to WAIT_FRAME.
- **WAIT_FRAME**: on `cam_frame_end`, set `cam_freeze` to 1 and go to START. Otherwise stay.
- **START**: `detect_color` = 1 for exactly this cycle. Clear the timeout counter. Go to BUSY.
- **BUSY**: the counter increments each cycle.
  - On `det_done`: latch `det_color` into `result`, set `result_err` = 0, go to REPLY.
  - On counter == TIMEOUT-1 without `det_done`: set `result` = 8'h45, `result_err` = 1, go to REPLY.
  - If both happen in the same cycle, `det_done` wins.
- **REPLY**: set `ack[gnt_id]` = 1 for the next cycle, `cam_freeze` = 0, `last_id` = `gnt_id`. Go to IDLE.

Round-robin arbitration:
- Single requester: it wins.
- Both requesting: the one not equal to `last_id` wins.
- `last_id` resets to 1, so `req[0]` wins the first tie.

Inputs ignored outside their state:
- `det_done` outside BUSY.
- `cam_frame_end` outside WAIT_FRAME.
- A requester dropping `req` after grant does not abort the scan; the scan completes and the `ack` is still issued.

Datapath and width rules:
- `result` is passed unmodified; codes other than R/G/B/N are forwarded as-is.
- Counter width is clog2(TIMEOUT); it does not wrap, because the exit happens at TIMEOUT-1.

Reset values:
- state IDLE, `gnt_id` 0, `last_id` 1.
- `ack` 2'b00, `result` 8'h00, `result_err` 0.
- `busy` 0, `cam_freeze` 0, `detect_color` 0, counter 0.

Reset mid-scan: all of the above take effect at the next edge. `cam_freeze` drops and no `ack` is issued. The detector shares `rst`, so no stale `det_done` arrives; if one does, it is ignored in IDLE.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- Grant latency: `req` high at edge n puts the arbiter in WAIT_FRAME after n; `busy` is high from n+1.
- `cam_frame_end` sampled at edge m: `cam_freeze` high after m, `detect_color` high during cycle m+1..m+2.
- `det_done` sampled at edge d: `result` valid after d, `ack` high during cycle d+1..d+2, `cam_freeze` low from d+1.
- Timeout: `ack` arrives TIMEOUT+1 cycles after the `detect_color` cycle.
- Back-to-back: the minimum gap between an `ack` and the next grant is 1 cycle (the IDLE-with-ack cycle).
- Minimum scan length with frame end already pending: 5 cycles from `req` to `ack`.

## Configuration
- `COLOR_SCAN_TIMEOUT_EN` defined: timeout counter and the `E`/`result_err` path are built as described.
- `COLOR_SCAN_TIMEOUT_EN` undefined:
  - no counter is built and `TIMEOUT` is unused;
  - BUSY exits only on `det_done`;
  - `result_err` is tied 0.

## Test plan
1. `req` = 01; `cam_frame_end` 10 cycles later; `det_done` with 8'h52 40 cycles after `detect_color` → one `ack` = 01 pulse, `result` 8'h52, `result_err` 0. Check that `cam_freeze` covers exactly from the frame-end edge to the `ack` edge and that `detect_color` is a single cycle.
2. `req` = 11 simultaneously, both held until their own `ack`; detector returns 8'h47 then 8'h42 → `ack` 01 with 8'h47, then `ack` 10 with 8'h42. `req[0]` is not re-granted while still high during its `ack` cycle.
3. After test 2 (`last_id` = 1), set `req` = 11 again → `req[0]` served first; then `req` = 01 alone twice → `req[0]` served both times.
4. `TIMEOUT` = 64 with the macro defined, no `det_done` → `ack` 65 cycles after `detect_color`, `result` 8'h45, `result_err` 1, `cam_freeze` released. With the macro undefined → `busy` remains high indefinitely.
5. `rst` high for one cycle during BUSY → next cycle all outputs at reset values, no `ack`. A `det_done` arriving after reset is ignored.
6. `det_done` (8'h4E) in the same cycle the counter hits TIMEOUT-1 → `result` 8'h4E, `result_err` 0. A `cam_frame_end` pulse during BUSY has no effect.

Source files
------------

// File: rtl/color_scan_arbiter.sv
// rtl/color_scan_arbiter.sv - round-robin arbiter sharing one color_detector between two requesters
// Optional macro COLOR_SCAN_TIMEOUT_EN builds the detector timeout counter and the 'E'/result_err path.
module color_scan_arbiter #(
    parameter int TIMEOUT = 16384
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] ack,
    output logic [7:0] result,
    output logic       result_err,
    output logic       busy,
    input  logic       cam_frame_end,
    output logic       cam_freeze,
    output logic       detect_color,
    input  logic       det_done,
    input  logic [7:0] det_color
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("color_scan_arbiter: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_START,
        S_BUSY,
        S_REPLY
    } state_e;

    state_e     state_q, state_d;
    logic       gnt_id_q, gnt_id_d;
    logic       last_id_q, last_id_d;
    logic [1:0] ack_q, ack_d;
    logic [7:0] result_q, result_d;
    logic       busy_q, busy_d;
    logic       freeze_q, freeze_d;
    logic       detect_q, detect_d;

`ifdef COLOR_SCAN_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timed_out;

    assign timed_out = (cnt_q == CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_id_q  <= 1'b0;
            last_id_q <= 1'b1;
            ack_q     <= 2'b00;
            result_q  <= 8'h00;
            busy_q    <= 1'b0;
            freeze_q  <= 1'b0;
            detect_q  <= 1'b0;
`ifdef COLOR_SCAN_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            ack_q     <= ack_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            freeze_q  <= freeze_d;
            detect_q  <= detect_d;
`ifdef COLOR_SCAN_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Requests are ignored while an ack is still out, so a requester that
    // has not yet dropped req is not granted a second scan.
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            S_IDLE: begin
                if (ack_q == 2'b00 && req != 2'b00) begin
                    state_d  = S_WAIT_FRAME;
                    gnt_id_d = (req == 2'b11) ? ~last_id_q : req[1];
                end
            end
            S_WAIT_FRAME: begin
                if (cam_frame_end) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_BUSY;
            S_BUSY: begin
                if (det_done) begin
                    state_d = S_REPLY;
                end
`ifdef COLOR_SCAN_TIMEOUT_EN
                else if (timed_out) begin
                    state_d = S_REPLY;
                end
`endif
            end
            S_REPLY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_d     = 2'b00;
        result_d  = result_q;
        busy_d    = (state_q != S_IDLE);
        freeze_d  = freeze_q;
        detect_d  = 1'b0;
        last_id_d = last_id_q;
`ifdef COLOR_SCAN_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_WAIT_FRAME: begin
                if (cam_frame_end) begin
                    freeze_d = 1'b1;
                end
            end
            S_START: begin
                detect_d = 1'b1;
`ifdef COLOR_SCAN_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            S_BUSY: begin
                // A done landing on the timeout cycle still delivers its colour.
                if (det_done) begin
                    result_d = det_color;
`ifdef COLOR_SCAN_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end
`ifdef COLOR_SCAN_TIMEOUT_EN
                else if (timed_out) begin
                    result_d = 8'h45;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_REPLY: begin
                ack_d[gnt_id_q] = 1'b1;
                freeze_d        = 1'b0;
                last_id_d       = gnt_id_q;
            end
            default: ;
        endcase
    end

    assign ack          = ack_q;
    assign result       = result_q;
    assign busy         = busy_q;
    assign cam_freeze   = freeze_q;
    assign detect_color = detect_q;
`ifdef COLOR_SCAN_TIMEOUT_EN
    assign result_err   = err_q;
`else
    assign result_err   = 1'b0;
`endif

endmodule

// File: tb/tb_color_scan_arbiter.sv
// tb/tb_color_scan_arbiter.sv - directed self-checking bench for color_scan_arbiter
module tb_color_scan_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] ack;
    logic [7:0] result;
    logic       result_err;
    logic       busy;
    logic       cam_frame_end;
    logic       cam_freeze;
    logic       detect_color;
    logic       det_done;
    logic [7:0] det_color;

    int tests_run    = 0;
    int tests_failed = 0;

    color_scan_arbiter #(.TIMEOUT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .ack          (ack),
        .result       (result),
        .result_err   (result_err),
        .busy         (busy),
        .cam_frame_end(cam_frame_end),
        .cam_freeze   (cam_freeze),
        .detect_color (detect_color),
        .det_done     (det_done),
        .det_color    (det_color)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one complete scan for whatever req is currently held; returns the first ack seen.
    task automatic run_scan(input logic [7:0] col, output logic [1:0] a, output logic [7:0] r, output logic e);
        step(2);
        cam_frame_end = 1'b1;
        step(1);
        cam_frame_end = 1'b0;
        step(1);
        det_color = col;
        det_done  = 1'b1;
        step(1);
        det_done  = 1'b0;
        a = 2'b00;
        for (int i = 0; i < 5 && a == 2'b00; i++) begin
            step(1);
            a = ack;
        end
        r = result;
        e = result_err;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; cam_frame_end = 1'b0; det_done = 1'b0; det_color = 8'h00;
        step(3);
        tests_run++;
        if ({ack, result, result_err, busy, cam_freeze, detect_color} !== 14'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ack=%b result=%h err=%b busy=%b freeze=%b detect=%b, want all zero",
                     ack, result, result_err, busy, cam_freeze, detect_color);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_single();
        int errs = 0;
        req = 2'b01;
        step(2);
        tests_run++;
        if (busy !== 1'b1 || cam_freeze !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_grant: got busy=%b freeze=%b, want busy=1 freeze=0", busy, cam_freeze);
        end
        step(8);
        cam_frame_end = 1'b1;
        step(1);
        cam_frame_end = 1'b0;
        tests_run++;
        if (cam_freeze !== 1'b1 || detect_color !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_freeze_on: got freeze=%b detect=%b, want 1 0", cam_freeze, detect_color);
        end
        step(1);
        tests_run++;
        if (detect_color !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_detect_pulse: got detect=%b, want 1", detect_color);
        end
        for (int i = 0; i < 39; i++) begin
            step(1);
            if (detect_color !== 1'b0 || ack !== 2'b00 || cam_freeze !== 1'b1) errs++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL single_wait_window: got %0d bad cycles, want 0", errs);
        end
        det_color = 8'h52;
        det_done  = 1'b1;
        step(1);
        det_done  = 1'b0;
        tests_run++;
        if (result !== 8'h52 || result_err !== 1'b0 || ack !== 2'b00 || cam_freeze !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_result_latch: got result=%h err=%b ack=%b freeze=%b, want 52 0 00 1",
                     result, result_err, ack, cam_freeze);
        end
        step(1);
        tests_run++;
        if (ack !== 2'b01 || cam_freeze !== 1'b0 || result !== 8'h52) begin
            tests_failed++;
            $display("FAIL single_ack: got ack=%b freeze=%b result=%h, want 01 0 52", ack, cam_freeze, result);
        end
        req = 2'b00;
        step(1);
        tests_run++;
        if (ack !== 2'b00 || result !== 8'h52) begin
            tests_failed++;
            $display("FAIL single_ack_one_cycle: got ack=%b result=%h, want 00 52", ack, result);
        end
        step(2);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] a;
        logic [7:0] r;
        logic       e;
        pulse_reset();
        req = 2'b11;
        run_scan(8'h47, a, r, e);
        tests_run++;
        if (a !== 2'b01 || r !== 8'h47 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_first: got ack=%b result=%h err=%b, want 01 47 0", a, r, e);
        end
        step(1);
        req = 2'b10;
        run_scan(8'h42, a, r, e);
        tests_run++;
        if (a !== 2'b10 || r !== 8'h42 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_second: got ack=%b result=%h err=%b, want 10 42 0", a, r, e);
        end
        req = 2'b00;
        step(2);
    endtask

    task automatic test_fairness();
        logic [1:0] a;
        logic [7:0] r;
        logic       e;
        req = 2'b11;
        run_scan(8'h52, a, r, e);
        tests_run++;
        if (a !== 2'b01 || r !== 8'h52) begin
            tests_failed++;
            $display("FAIL fair_tie_after_1: got ack=%b result=%h, want 01 52", a, r);
        end
        req = 2'b10;
        run_scan(8'h4E, a, r, e);
        tests_run++;
        if (a !== 2'b10 || r !== 8'h4E) begin
            tests_failed++;
            $display("FAIL fair_pending_1: got ack=%b result=%h, want 10 4e", a, r);
        end
        req = 2'b01;
        run_scan(8'h47, a, r, e);
        tests_run++;
        if (a !== 2'b01 || r !== 8'h47) begin
            tests_failed++;
            $display("FAIL fair_solo_a: got ack=%b result=%h, want 01 47", a, r);
        end
        step(1);
        req = 2'b00;
        step(2);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_regrant_in_ack_cycle: got busy=%b, want 0", busy);
        end
        req = 2'b01;
        run_scan(8'h37, a, r, e);
        tests_run++;
        if (a !== 2'b01 || r !== 8'h37) begin
            tests_failed++;
            $display("FAIL fair_solo_b: got ack=%b result=%h, want 01 37", a, r);
        end
        req = 2'b00;
        step(2);
    endtask

    task automatic test_timeout();
        int errs = 0;
        int cnt  = 0;
        logic seen = 1'b0;
        req = 2'b01;
        step(2);
        cam_frame_end = 1'b1;
        step(1);
        cam_frame_end = 1'b0;
        step(1);
        tests_run++;
        if (detect_color !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_detect: got detect=%b, want 1", detect_color);
        end
`ifdef COLOR_SCAN_TIMEOUT_EN
        while (!seen && cnt < 100) begin
            step(1);
            cnt++;
            if (ack !== 2'b00) seen = 1'b1;
        end
        tests_run++;
        if (cnt != 65 || ack !== 2'b01) begin
            tests_failed++;
            $display("FAIL timeout_latency: got %0d cycles ack=%b, want 65 cycles ack=01", cnt, ack);
        end
        tests_run++;
        if (result !== 8'h45 || result_err !== 1'b1 || cam_freeze !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_result: got result=%h err=%b freeze=%b, want 45 1 0", result, result_err, cam_freeze);
        end
        req = 2'b00;
        step(2);
`else
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (busy !== 1'b1 || ack !== 2'b00) errs++;
        end
        tests_run++;
        if (errs != 0 || seen || cnt != 0) begin
            tests_failed++;
            $display("FAIL no_timeout_hold: got %0d cycles not busy or acked, want 0", errs);
        end
        req = 2'b00;
        pulse_reset();
`endif
    endtask

    task automatic test_reset_mid_scan();
        int errs = 0;
        req = 2'b01;
        step(2);
        cam_frame_end = 1'b1;
        step(1);
        cam_frame_end = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        tests_run++;
        if ({ack, result, result_err, busy, cam_freeze, detect_color} !== 14'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_scan: got ack=%b result=%h err=%b busy=%b freeze=%b detect=%b, want all zero",
                     ack, result, result_err, busy, cam_freeze, detect_color);
        end
        rst = 1'b0;
        req = 2'b00;
        det_color = 8'h52;
        det_done  = 1'b1;
        step(1);
        det_done  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (ack !== 2'b00 || result !== 8'h00 || busy !== 1'b0) errs++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL stale_done_ignored: got %0d bad cycles, want 0", errs);
        end
    endtask

`ifdef COLOR_SCAN_TIMEOUT_EN
    task automatic test_done_vs_timeout();
        int errs = 0;
        req = 2'b01;
        step(2);
        cam_frame_end = 1'b1;
        step(1);
        cam_frame_end = 1'b0;
        step(1);
        for (int i = 0; i < 63; i++) begin
            step(1);
            cam_frame_end = (i == 10);
            if (detect_color !== 1'b0 || cam_freeze !== 1'b1 || ack !== 2'b00) errs++;
        end
        cam_frame_end = 1'b0;
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL frame_end_in_busy: got %0d bad cycles, want 0", errs);
        end
        det_color = 8'h4E;
        det_done  = 1'b1;
        step(1);
        det_done  = 1'b0;
        step(1);
        tests_run++;
        if (ack !== 2'b01 || result !== 8'h4E || result_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_beats_timeout: got ack=%b result=%h err=%b, want 01 4e 0", ack, result, result_err);
        end
        req = 2'b00;
        step(2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout();
        test_reset_mid_scan();
`ifdef COLOR_SCAN_TIMEOUT_EN
        test_done_vs_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
